// File: rtl/gth_lcg_checker.sv
// Checks a received GTH word stream against the transmit-side LCG sequence.
// Hunts for a seed, verifies a run of matches, then flywheels while locked and keeps error and loss statistics.
module gth_lcg_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter logic [31:0] MULT       = 32'd123,
  parameter logic [31:0] INC        = 32'd59
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_cnt,
  output logic [47:0] word_cnt,
  output logic [15:0] loss_cnt,
  output logic [1:0]  state_out
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  function automatic logic [31:0] lcg_next(input logic [31:0] cur);
    return cur * MULT + INC;
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_expected;
  logic [7:0]  r_match_run;
  logic [7:0]  r_miss_run;
  logic        r_err_pulse;
  logic [31:0] r_err_cnt;
  logic [47:0] r_word_cnt;
  logic [15:0] r_loss_cnt;

  logic        w_match;
  logic [31:0] w_f_exp;
  logic [31:0] w_f_data;
  logic        w_word_inc;
  logic        w_lock_err;
  logic        w_loss;

  assign w_match    = (rx_data == r_expected);
  assign w_f_exp    = lcg_next(r_expected);
  assign w_f_data   = lcg_next(rx_data);
  assign w_word_inc = rx_valid && (r_state == ST_LOCKED);
  assign w_lock_err = w_word_inc && !w_match;
  assign w_loss     = w_lock_err && (r_miss_run == LOSS_LAST);

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_state     <= ST_HUNT;
      r_expected  <= 32'd0;
      r_match_run <= 8'd0;
      r_miss_run  <= 8'd0;
    end else if (rx_valid) begin
      case (r_state)
        ST_HUNT: begin
          r_expected  <= w_f_data;
          r_match_run <= 8'd0;
          r_state     <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (w_match) begin
            r_expected <= w_f_exp;
            if (r_match_run == LOCK_LAST) begin
              r_state    <= ST_LOCKED;
              r_miss_run <= 8'd0;
            end else begin
              r_match_run <= r_match_run + 8'd1;
            end
          end else begin
            r_expected  <= w_f_data;
            r_match_run <= 8'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: never reseed from the line while locked.
          r_expected <= w_f_exp;
          if (!w_match) begin
            if (w_loss) begin
              r_state     <= ST_HUNT;
              r_miss_run  <= 8'd0;
              r_match_run <= 8'd0;
            end else begin
              r_miss_run <= r_miss_run + 8'd1;
            end
          end else begin
            r_miss_run <= 8'd0;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  // Statistics: clear wins over any same-cycle increment.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= 32'd0;
      r_word_cnt  <= 48'd0;
      r_loss_cnt  <= 16'd0;
    end else begin
      r_err_pulse <= w_lock_err;
      if (clear_cnt) begin
        r_err_cnt  <= 32'd0;
        r_word_cnt <= 48'd0;
        r_loss_cnt <= 16'd0;
      end else begin
        if (w_lock_err && (r_err_cnt != 32'hFFFF_FFFF))
          r_err_cnt <= r_err_cnt + 32'd1;
        if (w_word_inc)
          r_word_cnt <= r_word_cnt + 48'd1;
        if (w_loss && (r_loss_cnt != 16'hFFFF))
          r_loss_cnt <= r_loss_cnt + 16'd1;
      end
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign state_out = r_state;

endmodule

// File: tb/tb_gth_lcg_checker.sv
// Randomized scoreboard bench for gth_lcg_checker against a behavioural sequence-lock model.
module tb_gth_lcg_checker;

  localparam int unsigned LOCK = 16;
  localparam int unsigned LOSS = 4;
  localparam logic [31:0] MULT = 32'd123;
  localparam logic [31:0] INC  = 32'd59;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [31:0] err_cnt;
  logic [47:0] word_cnt;
  logic [15:0] loss_cnt;
  logic [1:0]  state_out;

  gth_lcg_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .MULT(MULT), .INC(INC)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .word_cnt(word_cnt), .loss_cnt(loss_cnt), .state_out(state_out)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [47:0] word_cnt;
    logic [15:0] loss_cnt;
    logic [1:0]  state;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: whole-stream view of the lock rules.
  int          m_state;   // 0 hunt, 1 verify, 2 locked
  logic [31:0] m_exp;
  int          m_run, m_miss;
  logic [31:0] m_err;
  logic [47:0] m_word;
  logic [15:0] m_loss;
  logic [31:0] tx;

  function automatic logic [31:0] f(input logic [31:0] cur);
    longint unsigned p;
    p = (longint'(cur) * longint'(MULT) + longint'(INC)) % 64'h1_0000_0000;
    return p[31:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_word = 0; m_loss = 0;
  endtask

  task automatic step(input logic [31:0] d, input logic v, input logic c);
    logic pulse;
    @(negedge rx_clk); #1;
    rx_data = d; rx_valid = v; clear_cnt = c;
    pulse = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        m_exp = f(d); m_run = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_exp = f(m_exp);
          if (m_run == LOCK - 1) begin m_state = 2; m_miss = 0; end
          else m_run++;
        end else begin
          m_exp = f(d); m_run = 0;
        end
      end else begin
        m_word = m_word + 48'd1;
        if (d != m_exp) begin
          pulse = 1'b1;
          if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
          m_miss++;
          if (m_miss == LOSS) begin
            m_state = 0; m_miss = 0; m_run = 0;
            if (m_loss != 16'hFFFF) m_loss = m_loss + 1;
          end
        end else m_miss = 0;
        m_exp = f(m_exp);
      end
    end
    if (c) begin m_err = 0; m_word = 0; m_loss = 0; end
    sb_q.push_back({m_state == 2, pulse, m_err, m_word, m_loss, 2'(m_state)});
  endtask

  task automatic send_good();
    step(tx, 1'b1, 1'b0); tx = f(tx);
  endtask

  task automatic send_bad(input logic c);
    step(tx ^ 32'h1, 1'b1, c); tx = f(tx);
  endtask

  task automatic chk_zero(input string name);
    obs_t a;
    a = {locked, err_pulse, err_cnt, word_cnt, loss_cnt, state_out};
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s: got %h expected all zero", name, a);
    end
  endtask

  task automatic async_reset(input string name);
    @(negedge rx_clk); #3;
    rx_valid = 1'b0; clear_cnt = 1'b0;
    rx_rst = 1'b1;
    #1 chk_zero(name);
    model_reset();
    #10;
    @(negedge rx_clk); #1 rx_rst = 1'b0;
  endtask

  // Monitor: every post-edge observation is compared against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge rx_clk);
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {locked, err_pulse, err_cnt, word_cnt, loss_cnt, state_out};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle %0d: got lk=%b ep=%b err=%0d word=%0d loss=%0d st=%0d, expected lk=%b ep=%b err=%0d word=%0d loss=%0d st=%0d",
                   cyc, a.locked, a.err_pulse, a.err_cnt, a.word_cnt, a.loss_cnt, a.state,
                   e.locked, e.err_pulse, e.err_cnt, e.word_cnt, e.loss_cnt, e.state);
        end
      end
    end
  end

  initial begin
    logic v, clr, bad;
    model_reset();
    #1 chk_zero("reset_initial");
    #12;
    @(negedge rx_clk); #1 rx_rst = 1'b0;

    repeat (6) step($urandom, 1'b1, 1'b0);

    // Documented seed: lock after 17th word.
    tx = 32'd3;
    repeat (LOCK + 1) send_good();
    repeat (5) send_good();

    // Single corrupted word.
    send_bad(1'b0);
    repeat (5) send_good();

    // Loss of lock, then relock.
    repeat (LOSS) send_bad(1'b0);
    repeat (LOCK + 4) send_good();

    // Valid gap.
    repeat (10) step($urandom, 1'b0, 1'b0);
    repeat (5) send_good();

    // Clear coinciding with a mismatch.
    send_bad(1'b1);
    repeat (3) send_good();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      bad = ($urandom_range(0, 19) == 0);
      if (!v) step($urandom, 1'b0, clr);
      else if ($urandom_range(0, 199) == 0) repeat (LOSS) send_bad(1'b0);
      else if (bad) begin
        step(tx ^ (32'h1 << $urandom_range(0, 31)), 1'b1, clr); tx = f(tx);
      end else begin
        step(tx, 1'b1, clr); tx = f(tx);
      end
    end

    // Build err_cnt=5 while locked, then reset mid-lock.
    repeat (LOCK + 2) send_good();
    step(tx, 1'b1, 1'b1); tx = f(tx);
    repeat (5) begin send_bad(1'b0); send_good(); end
    async_reset("reset_mid_lock");

    tx = $urandom;
    repeat (LOCK + 3) send_good();

    repeat (3) @(negedge rx_clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gth_lcg_checker.md
GTH_LCG_CHECKER -- requirements
Module: gth_lcg_checker

Interface
REQ-001 The block SHALL have the parameter LOCK_COUNT, default 16: the number of consecutive matching words needed to declare lock (allowed range 2..255).
REQ-002 The block SHALL have the parameter LOSS_COUNT, default 4: the number of consecutive mismatches in LOCKED that declares loss of lock (allowed range 1..255).
REQ-003 The block SHALL have the parameter MULT, default 123: the LCG multiplier.
REQ-004 The block SHALL have the parameter INC, default 59: the LCG increment.
REQ-005 The block SHALL have the port rx_clk  input  1: the single clock, the GTH RX user clock.
REQ-006 The block SHALL have the port rx_rst  input  1: asynchronous, active-high reset.
REQ-007 The block SHALL have the port rx_data  input  32: the received GTH user data word.
REQ-008 The block SHALL have the port rx_valid  input  1: rx_data is accepted on each rx_clk edge where rx_valid=1.
REQ-009 The block SHALL have the port clear_cnt  input  1: synchronous clear of all statistics counters.
REQ-010 The block SHALL have the port locked  output  1: high while in LOCKED.
REQ-011 The block SHALL have the port err_pulse  output  1: one-cycle pulse per mismatched word while in LOCKED.
REQ-012 The block SHALL have the port err_cnt  output  32: the count of mismatched words while LOCKED; it saturates.
REQ-013 The block SHALL have the port word_cnt  output  48: the count of words checked while LOCKED; it wraps.
REQ-014 The block SHALL have the port loss_cnt  output  16: the count of LOCKED->HUNT transitions; it saturates.
REQ-015 The block SHALL have the port state_out  output  2: the current state, encoded HUNT=0, VERIFY=1, LOCKED=2.

Function
REQ-016 The sequence model SHALL be next = (cur*MULT + INC) mod 2^32, matching the transmit-side generator; the product SHALL be truncated to 32 bits.
REQ-017 All state and outputs SHALL update only on rx_clk edges with rx_valid=1; exceptions are clear_cnt and the err_pulse deassert.
REQ-018 In HUNT, an accepted word SHALL load expected <= f(rx_data) and move to VERIFY with match_run=0.
REQ-019 In VERIFY, an accepted word equal to expected SHALL increment match_run and advance expected <= f(expected).
REQ-020 In VERIFY, when match_run reaches LOCK_COUNT-1 and the current word matches, the block SHALL go to LOCKED; locked SHALL be high on the cycle after that word.
REQ-021 In VERIFY, a mismatch SHALL reseed from the received word (expected <= f(rx_data), match_run=0) and stay in VERIFY.
REQ-022 In LOCKED, expected SHALL flywheel: expected <= f(expected) on every accepted word, matched or not; the block SHALL never reseed from rx_data while LOCKED.
REQ-023 In LOCKED, every accepted word SHALL increment word_cnt.
REQ-024 In LOCKED, each mismatch SHALL pulse err_pulse for exactly one cycle (the cycle after the word), increment err_cnt, and increment miss_run.
REQ-025 In LOCKED, a match SHALL clear miss_run.
REQ-026 In LOCKED, when miss_run reaches LOSS_COUNT, the block SHALL go to HUNT, increment loss_cnt, and drop locked on the next cycle; the word that triggers loss SHALL still be counted in err_cnt and word_cnt.
REQ-027 err_cnt SHALL hold at 0xFFFFFFFF once saturated.
REQ-028 loss_cnt SHALL hold at 0xFFFF once saturated.
REQ-029 word_cnt SHALL wrap from 2^48-1 to 0.
REQ-030 clear_cnt SHALL zero err_cnt, word_cnt and loss_cnt on the next edge, regardless of rx_valid.
REQ-031 When clear_cnt coincides with a counted event, clear SHALL take priority (the counter reads 0, not 1); err_pulse SHALL still fire.
REQ-032 clear_cnt SHALL NOT affect the state, expected, match_run or miss_run.
REQ-033 While rx_valid=0, the state, expected and all run counters SHALL hold, and err_pulse SHALL be 0.
REQ-034 The checker SHALL sustain one word per clock; rx_valid may be held high continuously.

Reset
REQ-035 rx_rst=1 SHALL force asynchronously: state=HUNT, expected=0, match_run=0, miss_run=0, locked=0, err_pulse=0, err_cnt=0, word_cnt=0, loss_cnt=0, state_out=0.
REQ-036 Release of rx_rst SHALL take effect at the first rx_clk edge after deassertion.
REQ-037 Reset asserted mid-lock SHALL discard all progress; no loss_cnt increment SHALL occur for a reset-induced exit.

Verification
REQ-038 Seed 3, then 3, 428, 52703, ... continuously, with defaults -> locked rises on the cycle after the 17th word; err_cnt=0.
REQ-039 Once locked, corrupt one word (XOR 0x1) -> a single err_pulse, err_cnt=1, locked stays 1, and the following correct words match with no further errors.
REQ-040 Once locked, corrupt 4 consecutive words -> err_cnt=4, loss_cnt=1, state_out=0; the stream resumes and relocks 17 words later.
REQ-041 Once locked, hold rx_valid=0 for 10 cycles, then resume with the next sequence word -> no errors; word_cnt increases only on valid cycles.
REQ-042 Assert clear_cnt on the same cycle as a mismatch -> err_cnt=0 afterwards, err_pulse=1 for that cycle, and locked unaffected.
REQ-043 Assert rx_rst asynchronously between clock edges while LOCKED with err_cnt=5 -> all outputs are 0 immediately and loss_cnt=0.
